// File: rtl/shift_sequencer_if.sv
// Command/result bundle for shift_sequencer: one command in, one result out.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start_valid;
  logic             start_ready;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start_valid, op, amt, data_in,
    input  start_ready, busy, done, result, err
  );

  modport slave (
    input  start_valid, op, amt, data_in,
    output start_ready, busy, done, result, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts one command, applies one single-bit
// shift per clock until the count is exhausted, then pulses done with the result.
module shift_sequencer #(
  parameter int WIDTH = 8,  // must be >= 2
  parameter int AMT_W = 3   // $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  cmd
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_BAD0 = 3'd0,
    OP_LSL  = 3'd1,
    OP_LSR  = 3'd2,
    OP_ASL  = 3'd3,
    OP_ASR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_BAD7 = 3'd7
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             accept;
  logic             op_valid;
  logic [WIDTH-1:0] step;

  assign cmd.start_ready = (state_q == IDLE);
  assign cmd.busy        = (state_q == SHIFT) || (state_q == DONE);
  assign cmd.done        = done_q;
  assign cmd.result      = w_q;
  assign cmd.err         = err_q;

  assign accept   = cmd.start_valid && (state_q == IDLE);
  assign op_valid = (cmd.op != OP_BAD0) && (cmd.op != OP_BAD7);

  // Single-bit step on the working register, selected by the latched op.
  always_comb begin
    step = w_q;
    case (op_q)
      OP_LSL, OP_ASL: step = {w_q[WIDTH-2:0], 1'b0};
      OP_LSR:         step = {1'b0, w_q[WIDTH-1:1]};
      OP_ASR:         step = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
      OP_ROL:         step = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      OP_ROR:         step = {w_q[0], w_q[WIDTH-1:1]};
      default:        step = w_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op_e'(cmd.op);
          w_d   = cmd.data_in;
          cnt_d = cmd.amt;
          err_d = 1'b0;
          if (!op_valid) begin
            w_d     = '0;
            err_d   = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
          end else if (cmd.amt == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        w_d = step;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - AMT_W'(1);
        end
        // Count of 1 means this edge applies the final step.
        if (cnt_q <= AMT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_BAD0;
      w_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule
